ir_decode_stage: RTL

Registered, parametrised successor to the combinational instruction decoder: accepts instruction words over a valid/ready handshake, decodes opcode and function fields into one-hot ALU selects plus ADD/ADDI/illegal flags, extracts register and immediate fields, and buffers decoded results in a DEPTH-entry queue toward the execute stage. It sits between the fetch and execute stages, absorbing execute backpressure without dropping instructions, and supports flush and a retired-decode counter.

---
 rtl/ir_decode_pkg.sv | 66 ++++++
 rtl/ir_decode_stage_queue.sv | 78 +++++++
 rtl/ir_decode_stage.sv | 106 ++++++++++
 3 files changed

// File: rtl/ir_decode_pkg.sv
// ir_decode_pkg
// Shared definitions for the registered instruction decode stage: opcode and
// ALU function field encodings, the bit positions of the one-hot ALU select,
// the decoded-record struct that travels through the output queue, and the
// pure decode function that turns a 16-bit instruction into that record.
package ir_decode_pkg;

    localparam logic [3:0] OP_ALU  = 4'b0101;
    localparam logic [3:0] OP_ADDI = 4'b1100;
    localparam logic [3:0] OP_ADD  = 4'b1110;

    localparam logic [3:0] FN_NOT = 4'b0000;
    localparam logic [3:0] FN_SUB = 4'b1000;
    localparam logic [3:0] FN_FAS = 4'b0100;
    localparam logic [3:0] FN_AND = 4'b0010;
    localparam logic [3:0] FN_OR  = 4'b0001;
    localparam logic [3:0] FN_XOR = 4'b0011;

    localparam int SEL_SUB = 0;
    localparam int SEL_FAS = 1;
    localparam int SEL_AND = 2;
    localparam int SEL_OR  = 3;
    localparam int SEL_XOR = 4;
    localparam int SEL_NOT = 5;
    localparam int SEL_W   = 6;

    // The immediate is stored as the raw 8-bit field; the top sign-extends it
    // to the configured output width so the struct stays parameter-free.
    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic             is_add;
        logic             is_addi;
        logic             illegal;
        logic [3:0]       rd;
        logic [3:0]       rs;
        logic [7:0]       imm;
    } dec_t;

    // Exactly one of {sel != 0, is_add, is_addi, illegal} ends up set.
    // Register and immediate fields are extracted for every instruction.
    function automatic dec_t decode(input logic [15:0] ir);
        dec_t d;
        d         = '0;
        d.rd      = ir[11:8];
        d.rs      = ir[7:4];
        d.imm     = ir[7:0];
        case (ir[15:12])
            OP_ALU: begin
                case (ir[3:0])
                    FN_NOT:  d.sel[SEL_NOT] = 1'b1;
                    FN_SUB:  d.sel[SEL_SUB] = 1'b1;
                    FN_FAS:  d.sel[SEL_FAS] = 1'b1;
                    FN_AND:  d.sel[SEL_AND] = 1'b1;
                    FN_OR:   d.sel[SEL_OR]  = 1'b1;
                    FN_XOR:  d.sel[SEL_XOR] = 1'b1;
                    default: d.illegal      = 1'b1;
                endcase
            end
            OP_ADDI: d.is_addi = 1'b1;
            OP_ADD:  d.is_add  = 1'b1;
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ir_decode_stage_queue.sv
// dec_queue
// DEPTH-entry synchronous FIFO of decoded records (dec_t).
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   flush       - empties the queue next cycle; same-cycle push/pop ignored
//   push, wr_data - write request and record (ignored when full)
//   pop         - consume head (ignored when empty)
//   rd_data     - head record (undefined when empty)
//   count, full, empty - occupancy status, all from registered state
module dec_queue
    import ir_decode_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  dec_t                       wr_data,
    input  logic                       pop,
    output dec_t                       rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count_q;
    dec_t          mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
    // pointers wrap naturally. Flush outranks any same-cycle push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: a slot is only ever read after being written,
    // and the stage zeroes its outputs whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/ir_decode_stage.sv
// ir_decode_stage
// Registered decode stage between fetch and execute. Instructions arrive over
// a valid/ready handshake, are decoded combinationally and the decoded record
// is buffered in a DEPTH-entry queue; execute sees only the queue head.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   flush               - drop all queued entries and the same-cycle input
//   in_valid/in_ready   - fetch handshake, in_ir is the instruction word
//   out_valid/out_ready - execute handshake for the head entry
//   out_sel             - one-hot {not,xor,or,and,fas,sub}
//   out_is_add, out_is_addi, out_illegal - head classification
//   out_rd, out_rs      - ir[11:8], ir[7:4] of the head
//   out_imm             - ir[7:0] of the head, sign-extended to DW
//   dec_cnt             - wrapping count of accepted legal instructions
module ir_decode_stage
    import ir_decode_pkg::*;
#(
    parameter int IW    = 16,
    parameter int DW    = 16,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IW-1:0]    in_ir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_sel,
    output logic             out_is_add,
    output logic             out_is_addi,
    output logic             out_illegal,
    output logic [3:0]       out_rd,
    output logic [3:0]       out_rs,
    output logic [DW-1:0]    out_imm,
    output logic [CNT_W-1:0] dec_cnt
);

    dec_t                   in_dec;
    dec_t                   head;
    logic                   push;
    logic                   pop;
    logic                   q_full;
    logic                   q_empty;
    logic [$clog2(DEPTH):0] q_count;
    logic                   unused_bits;

    // Only the low 16 instruction bits carry fields; occupancy is derived
    // from full/empty instead of the raw count.
    assign unused_bits = ^{in_ir, q_count};

    assign in_dec    = decode(in_ir[15:0]);
    assign in_ready  = ~q_full;
    assign out_valid = ~q_empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    dec_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .push    (push),
        .wr_data (in_dec),
        .pop     (pop),
        .rd_data (head),
        .count   (q_count),
        .full    (q_full),
        .empty   (q_empty)
    );

    // Counts accepted legal instructions; an input arriving together with a
    // flush is discarded and therefore not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_cnt <= '0;
        end else if (push && !flush && !in_dec.illegal) begin
            dec_cnt <= dec_cnt + CNT_W'(1);
        end
    end

    // Head payload is forced to zero whenever there is no valid entry, which
    // also makes every output drop to zero the moment reset is asserted.
    always_comb begin
        out_sel     = '0;
        out_is_add  = 1'b0;
        out_is_addi = 1'b0;
        out_illegal = 1'b0;
        out_rd      = '0;
        out_rs      = '0;
        out_imm     = '0;
        if (out_valid) begin
            out_sel     = head.sel;
            out_is_add  = head.is_add;
            out_is_addi = head.is_addi;
            out_illegal = head.illegal;
            out_rd      = head.rd;
            out_rs      = head.rs;
            out_imm     = DW'($signed(head.imm));
        end
    end

endmodule
